// File: rtl/dp_ram_async_read_core.sv
// Dual-port RAM with one clock, two independent write ports and combinational reads.
// A per-word valid bit hides unwritten or reset-cleared words, which read as zero.
module dp_ram_async_read_core #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 1000,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [MEM_DEPTH-1:0] ONE_L  = {{(MEM_DEPTH - 1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [MEM_DEPTH-1:0]  valid_q;
  logic [MEM_DEPTH-1:0]  valid_d;
  logic [MEM_DEPTH-1:0]  a_hot_s;
  logic [MEM_DEPTH-1:0]  b_hot_s;
  logic                  a_in_range_s;
  logic                  b_in_range_s;
  logic                  wa_en_s;
  logic                  wb_en_s;

  assign a_in_range_s = ({1'b0, addr_a} < DEPTH_L);
  assign b_in_range_s = ({1'b0, addr_b} < DEPTH_L);

  // Port A wins a same-address collision, so B's write is dropped outright.
  assign wa_en_s = we_a & a_in_range_s;
  assign wb_en_s = we_b & b_in_range_s & ~(wa_en_s & (addr_a == addr_b));

  assign a_hot_s = wa_en_s ? (ONE_L << addr_a) : {MEM_DEPTH{1'b0}};
  assign b_hot_s = wb_en_s ? (ONE_L << addr_b) : {MEM_DEPTH{1'b0}};
  assign valid_d = valid_q | a_hot_s | b_hot_s;

  // Valid bits: the only reset state in the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= {MEM_DEPTH{1'b0}};
    end else begin
      valid_q <= valid_d;
    end
  end

  // Data array: unreset storage, writes suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && wa_en_s) begin
      mem_q[addr_a] <= din_a;
    end
    if (rst_n && wb_en_s) begin
      mem_q[addr_b] <= din_b;
    end
  end

  assign dout_a = (a_in_range_s && valid_q[addr_a]) ? mem_q[addr_a] : {DATA_WIDTH{1'b0}};
  assign dout_b = (b_in_range_s && valid_q[addr_b]) ? mem_q[addr_b] : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_dp_ram_async_read_core.sv
// Self-checking bench for dp_ram_async_read_core: directed scenarios plus a
// randomized run compared against an array-based model of the memory.
module tb_dp_ram_async_read_core;

  localparam int DW    = 8;
  localparam int DEPTH = 1000;
  localparam int AW    = 10;

  logic          clk;
  logic          rst_n;
  logic          we_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] din_a;
  logic [DW-1:0] dout_a;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] din_b;
  logic [DW-1:0] dout_b;

  int n_checks;
  int n_fail;

  // Reference model: contents and a written flag per address.
  logic [DW-1:0] mem_m   [0:1023];
  bit            valid_m [0:1023];

  dp_ram_async_read_core #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_a   (we_a),
    .addr_a (addr_a),
    .din_a  (din_a),
    .dout_a (dout_a),
    .we_b   (we_b),
    .addr_b (addr_b),
    .din_b  (din_b),
    .dout_b (dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_read(input int a);
    if (a < DEPTH && valid_m[a]) return mem_m[a];
    return 8'h00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) valid_m[i] = 1'b0;
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic step();
    int a;
    int b;
    @(posedge clk);
    a = int'(addr_a);
    b = int'(addr_b);
    if (!rst_n) begin
      model_clear();
    end else begin
      if (we_a && a < DEPTH) begin
        mem_m[a] = din_a; valid_m[a] = 1'b1;
      end
      if (we_b && b < DEPTH && !(we_a && a == b)) begin
        mem_m[b] = din_b; valid_m[b] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic drive(input logic wa, input int aa, input logic [DW-1:0] da,
                       input logic wb, input int ab, input logic [DW-1:0] db);
    @(negedge clk);
    we_a = wa; addr_a = AW'(aa); din_a = da;
    we_b = wb; addr_b = AW'(ab); din_b = db;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1, 8'h00, 1'b0, 999, 8'h00);
    n_checks++;
    if (dout_a !== 8'h00) begin
      n_fail++; $display("FAIL reset_dout_a: got %h expected 00", dout_a);
    end
    n_checks++;
    if (dout_b !== 8'h00) begin
      n_fail++; $display("FAIL reset_dout_b: got %h expected 00", dout_b);
    end
    // A write while in reset must not land.
    drive(1'b1, 1, 8'h5A, 1'b1, 999, 8'hA5);
    step();
    n_checks++;
    if (dout_a !== 8'h00 || dout_b !== 8'h00) begin
      n_fail++; $display("FAIL write_in_reset: got %h/%h expected 00/00", dout_a, dout_b);
    end
    @(negedge clk);
    we_a = 1'b0; we_b = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    drive(1'b1, 1, 8'hAA, 1'b1, 2, 8'hBB);
    n_checks++;
    if (dout_a !== 8'h00) begin
      n_fail++; $display("FAIL basic_before_edge: got %h expected 00", dout_a);
    end
    step();
    n_checks++;
    if (dout_a !== 8'hAA) begin
      n_fail++; $display("FAIL basic_after_edge_a: got %h expected aa", dout_a);
    end
    drive(1'b0, 1, 8'h00, 1'b0, 2, 8'h00);
    n_checks++;
    if (dout_a !== 8'hAA) begin
      n_fail++; $display("FAIL basic_read_a: got %h expected aa", dout_a);
    end
    n_checks++;
    if (dout_b !== 8'hBB) begin
      n_fail++; $display("FAIL basic_read_b: got %h expected bb", dout_b);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 3, 8'h11, 1'b1, 4, 8'h22);
    step();
    step();
    drive(1'b0, 3, 8'h00, 1'b0, 4, 8'h00);
    n_checks++;
    if (dout_a !== 8'h11 || dout_b !== 8'h22) begin
      n_fail++; $display("FAIL hold_rewrite: got %h/%h expected 11/22", dout_a, dout_b);
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 5, 8'h55, 1'b1, 5, 8'h66);
    step();
    drive(1'b0, 5, 8'h00, 1'b0, 5, 8'h00);
    n_checks++;
    if (dout_a !== 8'h55) begin
      n_fail++; $display("FAIL collision_a: got %h expected 55", dout_a);
    end
    n_checks++;
    if (dout_b !== 8'h55) begin
      n_fail++; $display("FAIL collision_b: got %h expected 55", dout_b);
    end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1000, 8'h77, 1'b1, 1023, 8'h77);
    step();
    n_checks++;
    if (dout_a !== 8'h00 || dout_b !== 8'h00) begin
      n_fail++; $display("FAIL oor_read: got %h/%h expected 00/00", dout_a, dout_b);
    end
    drive(1'b0, 1, 8'h00, 1'b0, 2, 8'h00);
    n_checks++;
    if (dout_a !== 8'hAA || dout_b !== 8'hBB) begin
      n_fail++; $display("FAIL oor_no_side_effect: got %h/%h expected aa/bb", dout_a, dout_b);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1, 8'h00, 1'b0, 2, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    n_checks++;
    if (dout_a !== 8'h00 || dout_b !== 8'h00) begin
      n_fail++; $display("FAIL async_reset_clear: got %h/%h expected 00/00", dout_a, dout_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1, 8'h12, 1'b0, 2, 8'h00);
    step();
    n_checks++;
    if (dout_a !== 8'h12) begin
      n_fail++; $display("FAIL rewrite_after_reset: got %h expected 12", dout_a);
    end
    n_checks++;
    if (dout_b !== 8'h00) begin
      n_fail++; $display("FAIL stale_after_reset: got %h expected 00", dout_b);
    end
  endtask

  function automatic int pick_addr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(995, 1023));
    return int'($urandom_range(0, 15));
  endfunction

  task automatic test_random();
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), pick_addr(), 8'($urandom),
            1'($urandom_range(0, 1)), pick_addr(), 8'($urandom));
      ea = exp_read(int'(addr_a));
      eb = exp_read(int'(addr_b));
      n_checks++;
      if (dout_a !== ea || dout_b !== eb) begin
        n_fail++;
        $display("FAIL rand_pre_edge[%0d]: got %h/%h expected %h/%h", i, dout_a, dout_b, ea, eb);
      end
      step();
      ea = exp_read(int'(addr_a));
      eb = exp_read(int'(addr_b));
      n_checks++;
      if (dout_a !== ea || dout_b !== eb) begin
        n_fail++;
        $display("FAIL rand_post_edge[%0d]: got %h/%h expected %h/%h", i, dout_a, dout_b, ea, eb);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_clear();
    rst_n  = 1'b0;
    we_a   = 1'b0; addr_a = '0; din_a = '0;
    we_b   = 1'b0; addr_b = '0; din_b = '0;
    test_reset();
    test_basic();
    test_hold();
    test_collision();
    test_out_of_range();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
